// File: rtl/duty_ramp_controller.sv
// Command-shaping stage in front of the BLDC driver: slew-limits duty and, on a
// disable or direction reversal, ramps duty to zero and coasts until the rotor stops.
package duty_ramp_pkg;
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } rotation_direction_t;
endpackage

module duty_ramp_controller
  import duty_ramp_pkg::*;
#(
  parameter int unsigned clk_freq_hz       = 54_000_000,
  parameter int unsigned pwm_counter_width = 11,
  parameter int unsigned counter_width     = 32,
  parameter int unsigned ramp_step_us      = 100,
  parameter int unsigned ramp_step         = 8,
  parameter int unsigned max_duty          = 1003,
  parameter int unsigned stop_rpm          = 30,
  parameter int unsigned stop_timeout_ms   = 500
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         cmd_enable,
  input  rotation_direction_t          cmd_direction,
  input  logic [pwm_counter_width-1:0] cmd_duty,
  input  logic [counter_width-1:0]     rpm,
  input  logic [2:0]                   driver_state,
  input  logic                         hall_error,
  output logic                         enable,
  output rotation_direction_t          direction,
  output logic [pwm_counter_width-1:0] pwm_duty,
  output logic [1:0]                   ramp_state,
  output logic                         at_target
);
  localparam int unsigned W           = pwm_counter_width;
  localparam int unsigned TICK_CYCLES = clk_freq_hz / 1_000_000 * ramp_step_us;
  localparam int unsigned PRESC_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(64'(stop_timeout_ms) * 64'(clk_freq_hz) / 64'd1000);
  localparam logic [W-1:0] STEP_N   = W'(ramp_step);
  localparam logic [W:0]   STEP_EXT = {1'b0, STEP_N};
  localparam logic [W-1:0] MAX_DUTY = W'(max_duty);
  localparam logic [counter_width-1:0] STOP_RPM = counter_width'(stop_rpm);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    RAMP_DOWN = 2'd2,
    WAIT_STOP = 2'd3
  } ramp_state_t;

  ramp_state_t         state_q, state_d;
  logic                enable_q, enable_d;
  rotation_direction_t dir_q, dir_d;
  logic [W-1:0]        duty_q, duty_d;
  logic                at_target_q, at_target_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [31:0]         timeout_q, timeout_d;

  logic         tick_s, abort_s, gate_reset_s, match_s;
  logic [W-1:0] target_s, step_up_s, step_down_s, step_zero_s;
  logic [W:0]   up_sum_s, down_floor_s;

  // Prescaler, target clamp and candidate duty steps; the up path is one bit wider so it cannot wrap.
  always_comb begin
    presc_d      = (presc_q == PRESC_LAST) ? {PRESC_W{1'b0}} : presc_q + PRESC_ONE;
    tick_s       = (presc_q == PRESC_LAST);
    target_s     = (cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd_duty;
    up_sum_s     = {1'b0, duty_q} + STEP_EXT;
    down_floor_s = {1'b0, target_s} + STEP_EXT;
    step_up_s    = (up_sum_s > {1'b0, target_s}) ? target_s : up_sum_s[W-1:0];
    step_down_s  = ({1'b0, duty_q} >= down_floor_s) ? (duty_q - STEP_N) : target_s;
    step_zero_s  = (duty_q >= STEP_N) ? (duty_q - STEP_N) : {W{1'b0}};
    abort_s      = hall_error | (driver_state == 3'd3);
    gate_reset_s = (driver_state >= 3'd4) && (driver_state <= 3'd6);
    match_s      = cmd_enable && (cmd_direction == dir_q);
  end

  // Next-state logic: abort beats transitions, and transitions suppress that cycle's duty step.
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    dir_d     = dir_q;
    duty_d    = duty_q;
    timeout_d = (timeout_q != 32'd0) ? timeout_q - 32'd1 : 32'd0;
    if (abort_s && (state_q != IDLE)) begin
      state_d  = IDLE;
      enable_d = 1'b0;
      dir_d    = DIR_NONE;
      duty_d   = {W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          enable_d = 1'b0;
          dir_d    = DIR_NONE;
          duty_d   = {W{1'b0}};
          if (cmd_enable && (cmd_direction != DIR_NONE) && !abort_s) begin
            state_d  = RUN;
            enable_d = 1'b1;
            dir_d    = cmd_direction;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (!match_s) begin
            state_d = RAMP_DOWN;
          end else if (tick_s && !gate_reset_s) begin
            if (duty_q < target_s) begin
              duty_d = step_up_s;
            end else if (duty_q > target_s) begin
              duty_d = step_down_s;
            end else begin
              duty_d = duty_q;
            end
          end else begin
            duty_d = duty_q;
          end
        end
        RAMP_DOWN: begin
          if (match_s) begin
            state_d = RUN;
          end else if (duty_q == {W{1'b0}}) begin
            state_d   = WAIT_STOP;
            enable_d  = 1'b0;
            timeout_d = TIMEOUT_LOAD;
          end else if (tick_s) begin
            duty_d = step_zero_s;
          end else begin
            duty_d = duty_q;
          end
        end
        WAIT_STOP: begin
          enable_d = 1'b0;
          duty_d   = {W{1'b0}};
          if ((rpm <= STOP_RPM) || (timeout_q <= 32'd1)) begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: begin
          state_d  = IDLE;
          enable_d = 1'b0;
          dir_d    = DIR_NONE;
          duty_d   = {W{1'b0}};
        end
      endcase
    end
    at_target_d = (state_d == RUN) && (duty_d == target_s);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      dir_q       <= DIR_NONE;
      duty_q      <= {W{1'b0}};
      at_target_q <= 1'b0;
      presc_q     <= {PRESC_W{1'b0}};
      timeout_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      at_target_q <= at_target_d;
      presc_q     <= presc_d;
      timeout_q   <= timeout_d;
    end
  end

  assign enable     = enable_q;
  assign direction  = dir_q;
  assign pwm_duty   = duty_q;
  assign ramp_state = state_q;
  assign at_target  = at_target_q;
endmodule

// File: tb/tb_duty_ramp_controller.sv
// Directed bench for duty_ramp_controller: ramp, saturation, reversal, timeout, abort, freeze, reset.
module tb_duty_ramp_controller;
  import duty_ramp_pkg::*;

  logic                sys_clk = 1'b0;
  logic                reset_n;
  logic                cmd_enable;
  rotation_direction_t cmd_direction;
  logic [10:0]         cmd_duty;
  logic [31:0]         rpm;
  logic [2:0]          driver_state;
  logic                hall_error;
  logic                enable;
  rotation_direction_t direction;
  logic [10:0]         pwm_duty;
  logic [1:0]          ramp_state;
  logic                at_target;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  duty_ramp_controller #(
    .clk_freq_hz(10_000_000), .pwm_counter_width(11), .counter_width(32),
    .ramp_step_us(1), .ramp_step(4), .max_duty(1000), .stop_rpm(30), .stop_timeout_ms(1)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .cmd_enable(cmd_enable),
    .cmd_direction(cmd_direction), .cmd_duty(cmd_duty), .rpm(rpm),
    .driver_state(driver_state), .hall_error(hall_error), .enable(enable),
    .direction(direction), .pwm_duty(pwm_duty), .ramp_state(ramp_state),
    .at_target(at_target)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_duty_change(output int cyc);
    logic [10:0] start;
    start = pwm_duty;
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (pwm_duty == start && cyc < 40);
    if (pwm_duty == start) cyc = -1;
  endtask

  task automatic wait_duty(input logic [10:0] v, input int bound);
    int n = 0;
    while (pwm_duty !== v && n < bound) begin
      cycle();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_enable = 1'b0; cmd_direction = DIR_NONE; cmd_duty = 11'd0;
    rpm = 32'd500; driver_state = 3'd0; hall_error = 1'b0;
    #23;
    checks++; if ({enable, pwm_duty, ramp_state, at_target} !== 15'd0) begin errors++;
      $display("FAIL reset_outputs: got en=%0d duty=%0d st=%0d at=%0d expected all 0", enable, pwm_duty, ramp_state, at_target); end
    checks++; if (direction !== DIR_NONE) begin errors++;
      $display("FAIL reset_direction: got %0d expected 0", direction); end
    reset_n = 1'b1;
    cycles(5);
    checks++; if (ramp_state !== 2'd0 || enable !== 1'b0) begin errors++;
      $display("FAIL idle_hold: got st=%0d en=%0d expected 0 0", ramp_state, enable); end
  endtask

  task automatic test_startup();
    int c;
    int maxd = 0;
    cmd_direction = DIR_CW; cmd_duty = 11'd10; cmd_enable = 1'b1; driver_state = 3'd2;
    cycle();
    checks++; if (ramp_state !== 2'd1 || enable !== 1'b1 || direction !== DIR_CW || pwm_duty !== 11'd0) begin errors++;
      $display("FAIL run_entry: got st=%0d en=%0d dir=%0d duty=%0d expected 1 1 1 0", ramp_state, enable, direction, pwm_duty); end
    wait_duty_change(c);
    checks++; if (pwm_duty !== 11'd4 || at_target !== 1'b0) begin errors++;
      $display("FAIL start_step1: got duty=%0d at=%0d expected 4 0", pwm_duty, at_target); end
    wait_duty_change(c);
    checks++; if (pwm_duty !== 11'd8 || c != 10) begin errors++;
      $display("FAIL start_step2: got duty=%0d gap=%0d expected 8 10", pwm_duty, c); end
    wait_duty_change(c);
    checks++; if (pwm_duty !== 11'd10 || c != 10 || at_target !== 1'b1) begin errors++;
      $display("FAIL start_step3: got duty=%0d gap=%0d at=%0d expected 10 10 1", pwm_duty, c, at_target); end
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (int'(pwm_duty) > maxd) maxd = int'(pwm_duty);
    end
    checks++; if (maxd != 10 || at_target !== 1'b1) begin errors++;
      $display("FAIL start_hold: got max=%0d at=%0d expected 10 1", maxd, at_target); end
  endtask

  task automatic test_saturation();
    int c;
    cmd_duty = 11'd2000;
    wait_duty_change(c);
    checks++; if (pwm_duty !== 11'd14 || at_target !== 1'b0) begin errors++;
      $display("FAIL sat_first_step: got duty=%0d at=%0d expected 14 0", pwm_duty, at_target); end
    wait_duty(11'd1000, 3000);
    cycles(30);
    checks++; if (pwm_duty !== 11'd1000 || at_target !== 1'b1 || ramp_state !== 2'd1) begin errors++;
      $display("FAIL sat_hold: got duty=%0d at=%0d st=%0d expected 1000 1 1", pwm_duty, at_target, ramp_state); end
  endtask

  task automatic test_retarget_down();
    int c;
    cmd_duty = 11'd100;
    wait_duty_change(c);
    checks++; if (pwm_duty !== 11'd996 || ramp_state !== 2'd1) begin errors++;
      $display("FAIL retarget_step: got duty=%0d st=%0d expected 996 1", pwm_duty, ramp_state); end
    wait_duty(11'd100, 2500);
    checks++; if (pwm_duty !== 11'd100 || at_target !== 1'b1) begin errors++;
      $display("FAIL retarget_done: got duty=%0d at=%0d expected 100 1", pwm_duty, at_target); end
  endtask

  task automatic test_reversal();
    int prev = 100;
    int bad = 0;
    int n = 0;
    cmd_direction = DIR_CCW;
    cycle();
    checks++; if (ramp_state !== 2'd2 || pwm_duty !== 11'd100 || enable !== 1'b1 || at_target !== 1'b0) begin errors++;
      $display("FAIL rev_enter: got st=%0d duty=%0d en=%0d at=%0d expected 2 100 1 0", ramp_state, pwm_duty, enable, at_target); end
    while (ramp_state == 2'd2 && n < 400) begin
      cycle();
      n++;
      if (int'(pwm_duty) != prev) begin
        if (prev - int'(pwm_duty) != 4) bad++;
        prev = int'(pwm_duty);
      end
    end
    checks++; if (bad != 0 || ramp_state !== 2'd3 || enable !== 1'b0 || pwm_duty !== 11'd0) begin errors++;
      $display("FAIL rev_rampdown: got bad=%0d st=%0d en=%0d duty=%0d expected 0 3 0 0", bad, ramp_state, enable, pwm_duty); end
    cycles(3);
    checks++; if (ramp_state !== 2'd3) begin errors++;
      $display("FAIL rev_coast: got st=%0d expected 3", ramp_state); end
    rpm = 32'd25;
    cycle();
    checks++; if (ramp_state !== 2'd0 || enable !== 1'b0 || direction !== DIR_NONE) begin errors++;
      $display("FAIL rev_stopped: got st=%0d en=%0d dir=%0d expected 0 0 0", ramp_state, enable, direction); end
    cycle();
    checks++; if (ramp_state !== 2'd1 || direction !== DIR_CCW || enable !== 1'b1) begin errors++;
      $display("FAIL rev_restart: got st=%0d dir=%0d en=%0d expected 1 2 1", ramp_state, direction, enable); end
    rpm = 32'd500;
  endtask

  task automatic test_zero_duty();
    cmd_duty = 11'd0;
    cycles(30);
    checks++; if (ramp_state !== 2'd1 || pwm_duty !== 11'd0 || at_target !== 1'b1) begin errors++;
      $display("FAIL zero_duty: got st=%0d duty=%0d at=%0d expected 1 0 1", ramp_state, pwm_duty, at_target); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    cmd_enable = 1'b0;
    cycle();
    checks++; if (ramp_state !== 2'd2) begin errors++;
      $display("FAIL to_rampdown: got st=%0d expected 2", ramp_state); end
    cycle();
    while (ramp_state == 2'd3 && cnt < 12000) begin
      cnt++;
      cycle();
    end
    checks++; if (cnt != 10000 || ramp_state !== 2'd0) begin errors++;
      $display("FAIL timeout_len: got cycles=%0d st=%0d expected 10000 0", cnt, ramp_state); end
  endtask

  task automatic test_abort();
    cmd_direction = DIR_CW; cmd_duty = 11'd60; cmd_enable = 1'b1;
    cycle();
    wait_duty(11'd60, 300);
    checks++; if (pwm_duty !== 11'd60 || ramp_state !== 2'd1) begin errors++;
      $display("FAIL abort_setup: got duty=%0d st=%0d expected 60 1", pwm_duty, ramp_state); end
    hall_error = 1'b1;
    cycle();
    hall_error = 1'b0;
    checks++; if (enable !== 1'b0 || pwm_duty !== 11'd0 || ramp_state !== 2'd0 || direction !== DIR_NONE) begin errors++;
      $display("FAIL hall_abort: got en=%0d duty=%0d st=%0d dir=%0d expected 0 0 0 0", enable, pwm_duty, ramp_state, direction); end
    cycle();
    checks++; if (ramp_state !== 2'd1) begin errors++;
      $display("FAIL abort_rerun: got st=%0d expected 1", ramp_state); end
    driver_state = 3'd3;
    cycles(2);
    checks++; if (ramp_state !== 2'd0 || enable !== 1'b0) begin errors++;
      $display("FAIL drv_error_abort: got st=%0d en=%0d expected 0 0", ramp_state, enable); end
    driver_state = 3'd2;
  endtask

  task automatic test_gate_freeze();
    int bad = 0;
    int c;
    cycle();
    wait_duty(11'd60, 300);
    cmd_duty = 11'd200;
    driver_state = 3'd5;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (pwm_duty !== 11'd60) bad++;
    end
    checks++; if (bad != 0 || ramp_state !== 2'd1) begin errors++;
      $display("FAIL gate_freeze: got moved=%0d st=%0d expected 0 1", bad, ramp_state); end
    driver_state = 3'd2;
    wait_duty_change(c);
    checks++; if (pwm_duty !== 11'd64 || c < 1 || c > 10) begin errors++;
      $display("FAIL gate_resume: got duty=%0d wait=%0d expected 64 within 10", pwm_duty, c); end
  endtask

  task automatic test_async_reset();
    cmd_enable = 1'b0;
    cycle();
    checks++; if (ramp_state !== 2'd2 || pwm_duty !== 11'd64) begin errors++;
      $display("FAIL areset_setup: got st=%0d duty=%0d expected 2 64", ramp_state, pwm_duty); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({enable, pwm_duty, ramp_state, at_target} !== 15'd0 || direction !== DIR_NONE) begin errors++;
      $display("FAIL async_reset: got en=%0d duty=%0d st=%0d at=%0d dir=%0d expected all 0", enable, pwm_duty, ramp_state, at_target, direction); end
    #2;
    reset_n = 1'b1;
    cycle();
    checks++; if (ramp_state !== 2'd0) begin errors++;
      $display("FAIL post_reset: got st=%0d expected 0", ramp_state); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_saturation();
    test_retarget_down();
    test_reversal();
    test_zero_duty();
    test_timeout();
    test_abort();
    test_gate_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
